// File: rtl/acc_arbiter_pkg.sv
// Shared encodings for the two-requester accumulator arbiter: opcodes,
// arbitration FSM states and the default accumulator width.
package acc_arbiter_pkg;

   localparam int ACC_W_DEF = 16;

   typedef enum logic [1:0] {
      OP_ADD   = 2'b00,
      OP_CLEAR = 2'b01,
      OP_LOAD  = 2'b10,
      OP_NOP   = 2'b11
   } acc_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_OWN_A = 2'b01,
      ST_OWN_B = 2'b10
   } arb_state_t;

endpackage

// File: rtl/acc_core.sv
// Accumulator register with a sticky carry-out flag; one operation per
// enabled cycle.
module acc_core
   import acc_arbiter_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  acc_op_t          op,
   input  logic [ACC_W-1:0] operand,
   output logic [ACC_W-1:0] acc,
   output logic             ovf
);

   logic [ACC_W:0] sum;

   // One extra bit catches the carry out of the top accumulator bit.
   assign sum = {1'b0, acc} + {1'b0, operand};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (en) begin
         unique case (op)
            OP_ADD: begin
               acc <= sum[ACC_W-1:0];
               ovf <= ovf | sum[ACC_W];
            end
            OP_CLEAR: begin
               acc <= '0;
               ovf <= 1'b0;
            end
            OP_LOAD: begin
               acc <= operand;
               ovf <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/acc_arbiter.sv
// Round-robin arbiter with burst limiting that feeds one shared accumulator
// from two valid/ready requesters.
module acc_arbiter
   import acc_arbiter_pkg::*;
#(
   parameter int ACC_W     = ACC_W_DEF,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [7:0]       a_data,
   input  logic [1:0]       a_op,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [7:0]       b_data,
   input  logic [1:0]       b_op,
   output logic [ACC_W-1:0] acc_out,
   output logic             acc_vld,
   output logic             owner,
   output logic             ovf,
   output arb_state_t       state_dbg
);

   // Handshake: a beat transfers on a rising edge where x_valid && x_ready.
   // x_ready is a function of x_valid, FSM state and burst count only, and
   // never of data/op; at most one ready is high in any cycle.

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

   arb_state_t       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             grant_a, grant_b;
   logic             fire_a, fire_b, fire;
   logic [1:0]       sel_op;
   logic [7:0]       sel_data;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      grant_a  = 1'b0;
      grant_b  = 1'b0;
      unique case (state)
         // owner == 1 means B went last, so A takes the tie.
         ST_IDLE: begin
            if (a_valid && (!b_valid || owner)) grant_a = 1'b1;
            else if (b_valid)                   grant_b = 1'b1;
         end
         ST_OWN_A: begin
            if (a_valid && (cnt < MAX_CNT || !b_valid)) grant_a = 1'b1;
            else if (b_valid)                           grant_b = 1'b1;
         end
         ST_OWN_B: begin
            if (b_valid && (cnt < MAX_CNT || !a_valid)) grant_b = 1'b1;
            else if (a_valid)                           grant_a = 1'b1;
         end
         default: ;
      endcase

      // Count continues only for a repeat grant below the limit.
      if (grant_a) begin
         state_nx = ST_OWN_A;
         cnt_nx   = (state == ST_OWN_A && cnt < MAX_CNT) ? cnt + CNT_W'(1) : CNT_W'(1);
      end else if (grant_b) begin
         state_nx = ST_OWN_B;
         cnt_nx   = (state == ST_OWN_B && cnt < MAX_CNT) ? cnt + CNT_W'(1) : CNT_W'(1);
      end else begin
         state_nx = ST_IDLE;
         cnt_nx   = '0;
      end
   end

   assign a_ready   = grant_a & rst_n;
   assign b_ready   = grant_b & rst_n;
   assign fire_a    = a_valid & a_ready;
   assign fire_b    = b_valid & b_ready;
   assign fire      = fire_a | fire_b;
   assign sel_op    = fire_b ? b_op   : a_op;
   assign sel_data  = fire_b ? b_data : a_data;
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         owner   <= 1'b1;
         acc_vld <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         acc_vld <= fire;
         if (fire) owner <= fire_b;
      end
   end

   acc_core #(.ACC_W(ACC_W)) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (fire),
      .op      (acc_op_t'(sel_op)),
      .operand ({{(ACC_W-8){1'b0}}, sel_data}),
      .acc     (acc_out),
      .ovf     (ovf)
   );

endmodule

// File: tb/tb_acc_arbiter.sv
// Bench for acc_arbiter: fixed vector table, directed burst/wrap/reset
// sequences and random traffic against a cycle model with an expected queue.
module tb_acc_arbiter;
   import acc_arbiter_pkg::*;

   localparam int ACC_W     = 16;
   localparam int MAX_BURST = 4;
   localparam int W         = ACC_W + 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             a_valid = 1'b0, b_valid = 1'b0;
   logic [7:0]       a_data = '0, b_data = '0;
   logic [1:0]       a_op = '0, b_op = '0;
   logic             a_ready, b_ready, acc_vld, owner, ovf;
   logic [ACC_W-1:0] acc_out;
   arb_state_t       state_dbg;

   acc_arbiter #(.ACC_W(ACC_W), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_op(a_op),
      .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_op(b_op),
      .acc_out(acc_out), .acc_vld(acc_vld), .owner(owner), .ovf(ovf),
      .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   // scoreboard and reference model
   int               n_tests = 0;
   int               n_fail  = 0;
   logic [W-1:0]     exp_q[$];
   int               m_state, m_cnt;
   logic             m_owner, m_ovf;
   logic [ACC_W-1:0] m_acc;
   logic             samp_a, samp_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_owner = 1'b1; m_ovf = 1'b0; m_acc = '0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      a_valid = 1'b1; b_valid = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_acc_out", 32'(acc_out), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_acc_vld", 32'(acc_vld), 0);
      chk("rst_owner", 32'(owner), 1);
      chk("rst_a_ready", 32'(a_ready), 0);
      chk("rst_b_ready", 32'(b_ready), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0;
      model_reset();
   endtask

   // One cycle: drive, check grants before the edge, check results after.
   task automatic step(input logic av, input logic [1:0] aop, input logic [7:0] ad,
                       input logic bv, input logic [1:0] bop, input logic [7:0] bd);
      logic             ga, gb;
      logic [1:0]       op;
      logic [7:0]       d;
      logic [ACC_W:0]   s;
      logic [W-1:0]     e;
      a_valid = av; a_op = aop; a_data = ad;
      b_valid = bv; b_op = bop; b_data = bd;
      ga = 1'b0; gb = 1'b0;
      @(negedge clk);
      case (m_state)
         0: if (av && bv) begin ga = m_owner; gb = !m_owner; end
            else begin ga = av; gb = bv; end
         1: if (av && !(m_cnt == MAX_BURST && bv)) ga = 1'b1; else gb = bv;
         default: if (bv && !(m_cnt == MAX_BURST && av)) gb = 1'b1; else ga = av;
      endcase
      chk("a_ready", 32'(a_ready), 32'(ga));
      chk("b_ready", 32'(b_ready), 32'(gb));
      samp_a = a_ready; samp_b = b_ready;
      if (ga || gb) begin
         m_cnt   = ((ga && m_state == 1) || (gb && m_state == 2)) && m_cnt < MAX_BURST ? m_cnt + 1 : 1;
         m_state = ga ? 1 : 2;
         m_owner = gb;
         op = ga ? aop : bop;
         d  = ga ? ad : bd;
         case (op)
            OP_ADD: begin
               s = {1'b0, m_acc} + (ACC_W+1)'(d);
               m_acc = s[ACC_W-1:0];
               m_ovf = m_ovf | s[ACC_W];
            end
            OP_CLEAR: begin m_acc = '0; m_ovf = 1'b0; end
            OP_LOAD:  begin m_acc = ACC_W'(d); m_ovf = 1'b0; end
            default: ;
         endcase
         exp_q.push_back({m_ovf, m_owner, m_acc});
      end else begin
         m_state = 0; m_cnt = 0;
      end
      @(posedge clk); #1;
      if (acc_vld) begin
         if (exp_q.size() == 0) chk("unexpected_acc_vld", 32'(acc_vld), 0);
         else begin
            e = exp_q.pop_front();
            chk("acc_out", 32'(acc_out), 32'(e[ACC_W-1:0]));
            chk("owner", 32'(owner), 32'(e[ACC_W]));
            chk("ovf", 32'(ovf), 32'(e[ACC_W+1]));
         end
      end else begin
         if (exp_q.size() != 0) begin
            chk("missing_acc_vld", 32'(acc_vld), 1);
            void'(exp_q.pop_front());
         end
         chk("acc_hold", 32'(acc_out), 32'(m_acc));
      end
   endtask

   // vector table
   typedef struct {
      logic av; logic [1:0] aop; logic [7:0] ad;
      logic bv; logic [1:0] bop; logic [7:0] bd;
      logic ea; logic eb; logic [ACC_W-1:0] eacc; logic eown;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [ACC_W-1:0] prev;
      logic             av, bv;
      vecs[0] = '{1, OP_LOAD,  8'h10, 0, OP_NOP,   8'h00, 1, 0, 16'h0010, 0};
      vecs[1] = '{1, OP_ADD,   8'h05, 0, OP_NOP,   8'h00, 1, 0, 16'h0015, 0};
      vecs[2] = '{0, OP_ADD,   8'h77, 1, OP_ADD,   8'h03, 0, 1, 16'h0018, 1};
      vecs[3] = '{1, OP_ADD,   8'h01, 1, OP_ADD,   8'h01, 0, 1, 16'h0019, 1};
      vecs[4] = '{1, OP_NOP,   8'h00, 1, OP_CLEAR, 8'h00, 0, 1, 16'h0000, 1};
      vecs[5] = '{0, OP_ADD,   8'h09, 0, OP_ADD,   8'h09, 0, 0, 16'h0000, 1};
      vecs[6] = '{1, OP_ADD,   8'h02, 1, OP_ADD,   8'h02, 1, 0, 16'h0002, 0};

      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(vecs[i].av, vecs[i].aop, vecs[i].ad, vecs[i].bv, vecs[i].bop, vecs[i].bd);
         chk($sformatf("vec%0d_a_ready", i), 32'(samp_a), 32'(vecs[i].ea));
         chk($sformatf("vec%0d_b_ready", i), 32'(samp_b), 32'(vecs[i].eb));
         chk($sformatf("vec%0d_acc", i), 32'(acc_out), 32'(vecs[i].eacc));
         chk($sformatf("vec%0d_owner", i), 32'(owner), 32'(vecs[i].eown));
      end

      // Both requesters from reset: alternate every MAX_BURST beats, no gaps.
      do_reset();
      for (int i = 0; i < 24; i++) begin
         step(1, OP_ADD, 8'h01, 1, OP_ADD, 8'h01);
         chk("rr_a", 32'(samp_a), 32'((i / MAX_BURST) % 2 == 0));
         chk("rr_b", 32'(samp_b), 32'((i / MAX_BURST) % 2 == 1));
      end
      chk("rr_acc", 32'(acc_out), 24);

      // A alone streams past the limit; B raised mid-burst waits for beat 4.
      step(0, OP_NOP, 0, 0, OP_NOP, 0);
      for (int i = 0; i < 6; i++) begin
         step(1, OP_ADD, 8'h01, 0, OP_NOP, 0);
         chk("a_stream", 32'(samp_a), 1);
      end
      for (int k = 0; k < 3; k++) begin
         step(1, OP_ADD, 8'h01, 1, OP_ADD, 8'h01);
         chk("b_after_burst", 32'(samp_b), 32'(k == 2));
      end

      // A drops while B waits: B granted the same cycle, acc continuous.
      step(0, OP_NOP, 0, 0, OP_NOP, 0);
      for (int i = 0; i < 3; i++) step(1, OP_ADD, 8'h01, 0, OP_NOP, 0);
      prev = acc_out;
      step(0, OP_ADD, 8'h01, 1, OP_ADD, 8'h01);
      chk("switch_b_ready", 32'(samp_b), 1);
      chk("switch_acc", 32'(acc_out), 32'(prev + 16'd1));
      for (int i = 0; i < 5; i++) begin
         step(0, OP_NOP, 0, 1, OP_ADD, 8'h01);
         chk("b_stream", 32'(samp_b), 1);
      end
      for (int i = 0; i < 4; i++) step(1, OP_ADD, 8'h01, 1, OP_ADD, 8'h01);

      // Wrap: 0xFF loaded plus 257 adds of 0xFF crosses 0xFFFF on the last add.
      step(1, OP_LOAD, 8'hFF, 0, OP_NOP, 0);
      for (int i = 0; i < 257; i++) begin
         step(1, OP_ADD, 8'hFF, 0, OP_NOP, 0);
         if (i == 255) begin
            chk("pre_wrap_acc", 32'(acc_out), 32'hFFFF);
            chk("pre_wrap_ovf", 32'(ovf), 0);
         end
      end
      chk("wrap_acc", 32'(acc_out), 32'h00FE);
      chk("wrap_ovf", 32'(ovf), 1);
      step(1, OP_ADD, 8'h01, 0, OP_NOP, 0);
      step(0, OP_NOP, 0, 1, OP_ADD, 8'h01);
      chk("sticky_acc", 32'(acc_out), 32'h0100);
      chk("sticky_ovf", 32'(ovf), 1);
      step(0, OP_NOP, 0, 1, OP_CLEAR, 8'h5A);
      chk("clear_acc", 32'(acc_out), 0);
      chk("clear_ovf", 32'(ovf), 0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         av = ($urandom_range(0, 3) != 0);
         bv = ($urandom_range(0, 3) != 0);
         step(av, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
              bv, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      end

      // Asynchronous reset in the middle of a burst.
      step(1, OP_LOAD, 8'h30, 0, OP_NOP, 0);
      step(1, OP_ADD, 8'h03, 0, OP_NOP, 0);
      chk("pre_rst_acc", 32'(acc_out), 32'h0033);
      a_valid = 1'b1; a_op = OP_ADD; a_data = 8'h01; b_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_acc", 32'(acc_out), 0);
      chk("midrst_ovf", 32'(ovf), 0);
      chk("midrst_a_ready", 32'(a_ready), 0);
      chk("midrst_b_ready", 32'(b_ready), 0);
      @(posedge clk); #1;
      chk("midrst_acc_vld", 32'(acc_vld), 0);
      a_valid = 1'b0;
      rst_n = 1'b1;
      model_reset();
      step(0, OP_NOP, 0, 0, OP_NOP, 0);
      chk("post_rst_no_vld", 32'(acc_vld), 0);
      step(1, OP_ADD, 8'h04, 1, OP_ADD, 8'h08);
      chk("post_rst_tie_a", 32'(samp_a), 1);
      chk("post_rst_acc", 32'(acc_out), 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/acc_arbiter.md
ACC_ARBITER -- requirements
Module: acc_arbiter

Interface
REQ-001 Parameter ACC_W, default 16: accumulator width in bits.
REQ-002 Parameter MAX_BURST, default 4: maximum consecutive beats one requester may hold the grant while the other is waiting.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 a_valid  input  1  requester A has a beat pending.
REQ-006 a_ready  output  1  A's beat is accepted this cycle.
REQ-007 a_data  input  8  A's operand, zero-extended to ACC_W.
REQ-008 a_op  input  2  A's opcode: 00 ADD, 01 CLEAR, 10 LOAD, 11 NOP.
REQ-009 b_valid, b_ready, b_data, b_op  as A, for requester B.
REQ-010 acc_out  output  ACC_W  registered accumulator value.
REQ-011 acc_vld  output  1  one-cycle pulse: acc_out was updated by an accepted beat.
REQ-012 owner  output  1  registered; 0 = A, 1 = B; requester of the last accepted beat.
REQ-013 ovf  output  1  sticky carry-out of the accumulator.

Function
REQ-014 Transfer occurs when x_valid and x_ready are both high at a rising edge.
REQ-015 x_ready is combinational from x_valid, FSM state and burst count; at most one of a_ready/b_ready is high in any cycle.
REQ-016 x_ready never depends on x_data or x_op.
REQ-017 FSM states: IDLE, OWN_A, OWN_B.
REQ-018 IDLE, one valid: grant that requester; next state is its OWN state.
REQ-019 IDLE, both valid: grant the requester not named by owner (round-robin).
REQ-020 OWN_x, x valid, burst count < MAX_BURST: grant x; burst count increments.
REQ-021 OWN_x, x valid, count = MAX_BURST, other valid: grant the other; state switches; count = 1.
REQ-022 OWN_x, x valid, count = MAX_BURST, other idle: grant x; count restarts at 1.
REQ-023 OWN_x, x not valid, other valid: grant the other the same cycle; count = 1.
REQ-024 Neither valid: no grant; state returns to IDLE; count = 0.
REQ-025 Beat effects, applied at the accepting edge:
- ADD: acc += data.
- CLEAR: acc = 0, ovf = 0.
- LOAD: acc = data, ovf = 0.
- NOP: acc unchanged.
REQ-026 ADD wraps modulo 2^ACC_W; a carry out of bit ACC_W-1 sets ovf, which holds until CLEAR, LOAD or reset.
REQ-027 Latency: acc_out, ovf, owner and acc_vld reflect a beat exactly one cycle after acceptance.
REQ-028 acc_vld pulses for every accepted beat, including NOP.
REQ-029 Back-to-back beats from one requester are accepted on consecutive cycles with no bubble.
REQ-030 A grant switch (REQ-021, REQ-023) costs no idle cycle.

Reset
REQ-031 While rst_n is low: acc_out = 0, ovf = 0, acc_vld = 0, owner = 1 (A wins the first tie), state IDLE, burst count 0, a_ready = b_ready = 0.
REQ-032 Reset assertion mid-burst discards the in-flight beat; no acc_vld follows deassertion.
REQ-033 After rst_n rises, the first rising edge may accept a beat.

Structure
REQ-034 A shared package holds the opcode encodings, FSM state encodings and the ACC_W default.
REQ-035 Accumulator register and ovf logic live in one sub-module, acc_core (inputs: enable, op, operand; outputs: acc, ovf).
REQ-036 Arbitration FSM and burst counter live in acc_arbiter.

Verification
REQ-037 Reset, then A: LOAD 0x10 then ADD 0x05 -> acc_out 0x0010 then 0x0015; acc_vld high on both cycles; owner = 0.
REQ-038 A and B both valid from reset with ADD 0x01 -> A accepted 4 beats, then B 4 beats, then alternating every 4 beats; no idle cycle at any switch.
REQ-039 LOAD 0xFF, then ADD 0xFF repeated 257 times -> acc_out wraps past 0xFFFF; ovf set at the first wrap and stays set; a later CLEAR -> acc_out 0, ovf 0.
REQ-040 A valid continuously, B idle -> A accepted every cycle indefinitely; B raised mid-burst -> B granted after A's 4th beat of the current burst.
REQ-041 A streaming ADD 0x01, A deasserts with B valid -> B granted in the same cycle; count restarts; acc_out continuous.
REQ-042 rst_n pulsed low mid-burst (acc_out 0x0033) -> acc_out 0, ovf 0, ready outputs 0 immediately; A wins the next tie.
